el2_ic_dbg_seq: RTL and testbench

- Sequences debugger/CSR-initiated I-cache diagnostic accesses: dicago reads and writes of tag and data arrays.
- Latches the dicawics index/way/array select and the write data.
- Waits for the I-cache to go idle, then issues a single-cycle rd/wr valid inside an el2_cache_debug_pkt_t.
- Waits for the I-cache acknowledge, captures read data, and reports done or error to the DEC TLU CSR logic.

---
 rtl/el2_ic_dbg_seq.sv | 146 ++++++++++++++
 tb/tb_el2_ic_dbg_seq.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_ic_dbg_seq.sv
// I-cache diagnostic access sequencer: latches a dicago request, waits for the I-cache to idle,
// issues one rd/wr valid and waits for the ack. Optional ack-wait watchdog: EL2_IC_DBG_TIMEOUT_EN.
module el2_ic_dbg_seq #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_go,
  input  logic        dbg_wr,
  input  logic [16:0] dbg_dicawics,
  input  logic [70:0] dbg_wrdata,
  input  logic        dbg_abort,
  input  logic        ic_busy,
  input  logic        ic_dbg_ack,
  input  logic [70:0] ic_dbg_rd_data,
  output logic [89:0] ic_dbg_pkt,
  output logic        dbg_busy,
  output logic        dbg_done,
  output logic [70:0] dbg_rd_data,
  output logic        dbg_err
);

  typedef struct packed {
    logic [70:0] icache_wrdata;
    logic [16:0] icache_dicawics;
    logic        icache_rd_valid;
    logic        icache_wr_valid;
  } el2_cache_debug_pkt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state, state_nxt;
  el2_cache_debug_pkt_t pkt, pkt_nxt;
  logic                 wr_q, wr_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic [70:0]          rd_data_nxt;
  logic                 ack_ok;
  logic                 timeout;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("el2_ic_dbg_seq: TIMEOUT_CYC must be within 1..65535");
  end

  // An ack coincident with our own valid pulse cannot belong to this access.
  assign ack_ok = ic_dbg_ack & ~(pkt.icache_rd_valid | pkt.icache_wr_valid);

`ifdef EL2_IC_DBG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == WAIT && state_nxt == WAIT) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_nxt               = state;
    pkt_nxt                 = pkt;
    pkt_nxt.icache_rd_valid = 1'b0;
    pkt_nxt.icache_wr_valid = 1'b0;
    wr_nxt                  = wr_q;
    done_nxt                = 1'b0;
    err_nxt                 = dbg_err;
    rd_data_nxt             = dbg_rd_data;

    case (state)
      IDLE: begin
        if (dbg_go && !dbg_abort) begin
          wr_nxt                  = dbg_wr;
          pkt_nxt.icache_dicawics = dbg_dicawics;
          pkt_nxt.icache_wrdata   = dbg_wrdata;
          err_nxt                 = 1'b0;
          state_nxt               = ARB;
        end
      end
      ARB: begin
        if (dbg_abort) begin
          state_nxt = IDLE;
        end else if (!ic_busy) begin
          pkt_nxt.icache_rd_valid = ~wr_q;
          pkt_nxt.icache_wr_valid = wr_q;
          state_nxt               = WAIT;
        end
      end
      WAIT: begin
        // Ack outranks both abort and timeout in the same cycle.
        if (ack_ok) begin
          if (!wr_q) begin
            rd_data_nxt = ic_dbg_rd_data;
          end
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (dbg_abort) begin
          state_nxt = IDLE;
        end else if (timeout) begin
          err_nxt   = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= IDLE;
      pkt         <= '0;
      wr_q        <= 1'b0;
      dbg_busy    <= 1'b0;
      dbg_done    <= 1'b0;
      dbg_rd_data <= '0;
      dbg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pkt         <= pkt_nxt;
      wr_q        <= wr_nxt;
      dbg_busy    <= busy_nxt;
      dbg_done    <= done_nxt;
      dbg_rd_data <= rd_data_nxt;
      dbg_err     <= err_nxt;
    end
  end

  assign ic_dbg_pkt = pkt;

endmodule

// File: tb/tb_el2_ic_dbg_seq.sv
// Directed scoreboard bench for el2_ic_dbg_seq; timeout steps run only with EL2_IC_DBG_TIMEOUT_EN.
module tb_el2_ic_dbg_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_go, dbg_wr, dbg_abort, ic_busy, ic_dbg_ack;
  logic [16:0] dbg_dicawics;
  logic [70:0] dbg_wrdata, ic_dbg_rd_data;
  logic [89:0] ic_dbg_pkt;
  logic        dbg_busy, dbg_done, dbg_err;
  logic [70:0] dbg_rd_data;

  always #5 clk = ~clk;

  el2_ic_dbg_seq #(.TIMEOUT_CYC(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_go         (dbg_go),
    .dbg_wr         (dbg_wr),
    .dbg_dicawics   (dbg_dicawics),
    .dbg_wrdata     (dbg_wrdata),
    .dbg_abort      (dbg_abort),
    .ic_busy        (ic_busy),
    .ic_dbg_ack     (ic_dbg_ack),
    .ic_dbg_rd_data (ic_dbg_rd_data),
    .ic_dbg_pkt     (ic_dbg_pkt),
    .dbg_busy       (dbg_busy),
    .dbg_done       (dbg_done),
    .dbg_rd_data    (dbg_rd_data),
    .dbg_err        (dbg_err)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [16:0] wics;
    logic [70:0] wdata;
  } issue_t;

  typedef struct {
    logic [70:0] rd_data;
    logic        err;
  } done_t;

  issue_t      iss_q[$];
  done_t       done_q[$];
  int          total = 0;
  int          bad = 0;
  logic [70:0] exp_rd;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse dbg_go for one cycle, then scramble the sampled inputs to prove they were latched.
  task automatic go(input logic wr, input logic [16:0] wics, input logic [70:0] wd, input bit expect_issue);
    if (expect_issue) iss_q.push_back('{rd: ~wr, wr: wr, wics: wics, wdata: wd});
    dbg_go       = 1'b1;
    dbg_wr       = wr;
    dbg_dicawics = wics;
    dbg_wrdata   = wd;
    tick();
    dbg_go       = 1'b0;
    dbg_wr       = ~wr;
    dbg_dicawics = ~wics;
    dbg_wrdata   = ~wd;
  endtask

  task automatic compare_issue(input string tag);
    issue_t e;
    if (iss_q.size() == 0) begin
      check({tag, "_sb"}, 96'(iss_q.size()), 96'd1);
    end else begin
      e = iss_q.pop_front();
      check(tag, 96'(ic_dbg_pkt), 96'({e.wdata, e.wics, e.rd, e.wr}));
    end
  endtask

  task automatic wait_issue(input string tag, input int max_cyc);
    bit found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      tick();
      if (ic_dbg_pkt[1:0] != 2'b00) found = 1'b1;
    end
    check({tag, "_seen"}, 96'(found), 96'd1);
    if (found) compare_issue(tag);
    else if (iss_q.size() != 0) void'(iss_q.pop_front());
  endtask

  task automatic got_done(input string tag);
    done_t e;
    check({tag, "_done"}, 96'(dbg_done), 96'd1);
    check({tag, "_busy"}, 96'(dbg_busy), 96'd0);
    if (done_q.size() == 0) begin
      check({tag, "_sb"}, 96'(done_q.size()), 96'd1);
    end else begin
      e = done_q.pop_front();
      check({tag, "_rd"}, 96'(dbg_rd_data), 96'(e.rd_data));
      check({tag, "_err"}, 96'(dbg_err), 96'(e.err));
    end
  endtask

  task automatic ack_with(input logic [70:0] data, input logic [70:0] exp_data, input logic exp_err);
    done_q.push_back('{rd_data: exp_data, err: exp_err});
    ic_dbg_ack     = 1'b1;
    ic_dbg_rd_data = data;
    tick();
    ic_dbg_ack     = 1'b0;
    ic_dbg_rd_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; dbg_go = 1'b0; dbg_wr = 1'b0; dbg_abort = 1'b0; ic_busy = 1'b0;
    ic_dbg_ack = 1'b0; dbg_dicawics = '0; dbg_wrdata = '0; ic_dbg_rd_data = '0;
    exp_rd = '0;
    tick(); tick();
    check("rst_pkt", 96'(ic_dbg_pkt), 96'd0);
    check("rst_busy", 96'(dbg_busy), 96'd0);
    check("rst_done", 96'(dbg_done), 96'd0);
    check("rst_rd", 96'(dbg_rd_data), 96'd0);
    check("rst_err", 96'(dbg_err), 96'd0);
    rst = 1'b0;
    tick();

    // Read with idle I-cache: valid on go+2, ack the cycle after the pulse.
    go(1'b0, 17'h1_0A3, 71'h0, 1'b1);
    check("s1_lat1_valid", 96'(ic_dbg_pkt[1:0]), 96'd0);
    check("s1_lat1_busy", 96'(dbg_busy), 96'd1);
    tick();
    compare_issue("s1_issue");
    tick();
    check("s1_pulse_end", 96'(ic_dbg_pkt[1:0]), 96'd0);
    exp_rd = 71'h55_DEADBEEF_CAFEF00D;
    ack_with(71'h55_DEADBEEF_CAFEF00D, exp_rd, 1'b0);
    got_done("s1");
    tick();
    check("s1_done_1cyc", 96'(dbg_done), 96'd0);

    // Write held off by ic_busy; read data must not move.
    ic_busy = 1'b1;
    go(1'b1, 17'h0_1F4, 71'h7A_0123_4567_89AB_CDEF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_hold_novalid", 96'(ic_dbg_pkt[1:0]), 96'd0);
    end
    ic_busy = 1'b0;
    wait_issue("s2_issue", 4);
    tick();
    check("s2_pulse_end", 96'(ic_dbg_pkt[1:0]), 96'd0);
    tick();
    check("s2_single_pulse", 96'(ic_dbg_pkt[1:0]), 96'd0);
    ack_with(71'h3F_FFFF_0000_1111_2222, exp_rd, 1'b0);
    got_done("s2");

    // Second go during WAIT is ignored.
    go(1'b0, 17'h0_0ABC, 71'h11, 1'b1);
    tick();
    compare_issue("s3_issue");
    tick();
    dbg_go = 1'b1; dbg_wr = 1'b1; dbg_dicawics = 17'h1_5555; dbg_wrdata = 71'h2A;
    tick();
    dbg_go = 1'b0;
    check("s3_wics_kept", 96'(ic_dbg_pkt[18:2]), 96'h0ABC);
    check("s3_wdata_kept", 96'(ic_dbg_pkt[89:19]), 96'h11);
    check("s3_busy", 96'(dbg_busy), 96'd1);
    tick();
    check("s3_novalid", 96'(ic_dbg_pkt[1:0]), 96'd0);
    exp_rd = 71'h12_3456_789A_BCDE_F012;
    ack_with(71'h12_3456_789A_BCDE_F012, exp_rd, 1'b0);
    got_done("s3");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s3_one_done", 96'(dbg_done), 96'd0);
      check("s3_idle", 96'(dbg_busy), 96'd0);
    end

    // Abort during WAIT: back to IDLE, no done.
    go(1'b0, 17'h0_0111, 71'h0, 1'b1);
    tick();
    compare_issue("s4a_issue");
    tick();
    dbg_abort = 1'b1;
    tick();
    dbg_abort = 1'b0;
    check("s4a_busy", 96'(dbg_busy), 96'd0);
    check("s4a_nodone", 96'(dbg_done), 96'd0);
    tick();
    check("s4a_nodone2", 96'(dbg_done), 96'd0);
    check("s4a_rd_kept", 96'(dbg_rd_data), 96'(exp_rd));
    check("s4a_err", 96'(dbg_err), 96'd0);

    // Abort in the ARB issue cycle suppresses the valid.
    ic_busy = 1'b1;
    go(1'b0, 17'h0_0222, 71'h0, 1'b0);
    ic_busy = 1'b0;
    dbg_abort = 1'b1;
    tick();
    dbg_abort = 1'b0;
    check("s4b_novalid", 96'(ic_dbg_pkt[1:0]), 96'd0);
    check("s4b_busy", 96'(dbg_busy), 96'd0);
    tick();
    check("s4b_novalid2", 96'(ic_dbg_pkt[1:0]), 96'd0);

    // Abort together with go in IDLE: go ignored.
    dbg_go = 1'b1; dbg_abort = 1'b1; dbg_wr = 1'b0;
    tick();
    dbg_go = 1'b0; dbg_abort = 1'b0;
    check("s4e_busy", 96'(dbg_busy), 96'd0);
    tick();
    check("s4e_novalid", 96'(ic_dbg_pkt[1:0]), 96'd0);

    // Ack and abort together: ack wins.
    go(1'b1, 17'h1_0333, 71'h44_5566_7788_99AA_BBCC, 1'b1);
    tick();
    compare_issue("s4c_issue");
    tick();
    dbg_abort = 1'b1;
    ack_with(71'h1, exp_rd, 1'b0);
    dbg_abort = 1'b0;
    got_done("s4c");

    // Back-to-back go in the done cycle.
    go(1'b0, 17'h1_0444, 71'h0, 1'b1);
    check("s4d_busy", 96'(dbg_busy), 96'd1);
    tick();
    compare_issue("s4d_issue");
    tick();
    exp_rd = 71'h0F_0E0D_0C0B_0A09_0807;
    ack_with(71'h0F_0E0D_0C0B_0A09_0807, exp_rd, 1'b0);
    got_done("s4d");

`ifdef EL2_IC_DBG_TIMEOUT_EN
    // No ack: timeout decided in the 8th cycle after entering WAIT, done/err registered next.
    go(1'b0, 17'h0_0555, 71'h0, 1'b1);
    tick();
    compare_issue("s5_issue");
    for (int i = 0; i < 8; i++) begin
      tick();
      check("s5_no_early_done", 96'(dbg_done), 96'd0);
    end
    done_q.push_back('{rd_data: exp_rd, err: 1'b1});
    tick();
    got_done("s5_timeout");
    go(1'b0, 17'h0_0666, 71'h0, 1'b1);
    check("s5_err_cleared", 96'(dbg_err), 96'd0);
    tick();
    compare_issue("s5b_issue");
    for (int i = 0; i < 8; i++) tick();
    exp_rd = 71'h6B_1234_5678_9ABC_DEF0;
    ack_with(71'h6B_1234_5678_9ABC_DEF0, exp_rd, 1'b0);
    got_done("s5b_ack_at_limit");
`endif

    // Asynchronous reset mid-access.
    go(1'b0, 17'h1_0777, 71'h5, 1'b1);
    tick();
    compare_issue("s6_issue");
    tick();
    #2 rst = 1'b1;
    #1;
    check("s6_rst_pkt", 96'(ic_dbg_pkt), 96'd0);
    check("s6_rst_busy", 96'(dbg_busy), 96'd0);
    check("s6_rst_done", 96'(dbg_done), 96'd0);
    check("s6_rst_rd", 96'(dbg_rd_data), 96'd0);
    check("s6_rst_err", 96'(dbg_err), 96'd0);
    exp_rd = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    ic_dbg_ack = 1'b1; ic_dbg_rd_data = 71'h7F;
    tick();
    ic_dbg_ack = 1'b0; ic_dbg_rd_data = '0;
    check("s6_late_ack_done", 96'(dbg_done), 96'd0);
    check("s6_late_ack_busy", 96'(dbg_busy), 96'd0);
    check("s6_late_ack_rd", 96'(dbg_rd_data), 96'd0);
    go(1'b0, 17'h0_0888, 71'h0, 1'b1);
    tick();
    compare_issue("s6b_issue");
    tick();
    exp_rd = 71'h22_0000_0000_0000_1111;
    ack_with(71'h22_0000_0000_0000_1111, exp_rd, 1'b0);
    got_done("s6b");

    check("sb_empty", 96'(iss_q.size() + done_q.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
